// File: rtl/multicycle_main_control_pkg.sv
// Shared encodings for the multicycle MIPS control path: FSM states, opcodes and
// the 2-bit ALU_op codes that the ALU control decoder also consumes.
package multicycle_main_control_pkg;

  localparam logic [3:0] ST_IDLE      = 4'd0;
  localparam logic [3:0] ST_FETCH     = 4'd1;
  localparam logic [3:0] ST_DECODE    = 4'd2;
  localparam logic [3:0] ST_MEM_ADDR  = 4'd3;
  localparam logic [3:0] ST_MEM_READ  = 4'd4;
  localparam logic [3:0] ST_MEM_WB    = 4'd5;
  localparam logic [3:0] ST_MEM_WRITE = 4'd6;
  localparam logic [3:0] ST_EXECUTE   = 4'd7;
  localparam logic [3:0] ST_R_WB      = 4'd8;
  localparam logic [3:0] ST_BRANCH    = 4'd9;
  localparam logic [3:0] ST_JUMP      = 4'd10;
  localparam logic [3:0] ST_IMM_EXEC  = 4'd11;
  localparam logic [3:0] ST_IMM_WB    = 4'd12;

  typedef enum logic [3:0] {
    IDLE      = ST_IDLE,
    FETCH     = ST_FETCH,
    DECODE    = ST_DECODE,
    MEM_ADDR  = ST_MEM_ADDR,
    MEM_READ  = ST_MEM_READ,
    MEM_WB    = ST_MEM_WB,
    MEM_WRITE = ST_MEM_WRITE,
    EXECUTE   = ST_EXECUTE,
    R_WB      = ST_R_WB,
    BRANCH    = ST_BRANCH,
    JUMP      = ST_JUMP,
    IMM_EXEC  = ST_IMM_EXEC,
    IMM_WB    = ST_IMM_WB
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_AND   = 2'b11;

endpackage

// File: rtl/multicycle_main_control_instr_counter.sv
// Enable-increment counter with async active-high reset; wraps modulo 2^CNT_W.
module instr_counter #(
  parameter int CNT_W = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  output logic [CNT_W-1:0] o_count
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_count <= '0;
    else if (i_en) r_count <= r_count + 1'b1;
  end

  assign o_count = r_count;

endmodule

// File: rtl/multicycle_main_control.sv
// Main control FSM of the multicycle MIPS core: sequences each instruction from the
// IR opcode, drives datapath selects/strobes, counts retirements, flags bad opcodes.
module multicycle_main_control
  import multicycle_main_control_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic [1:0]       pc_source,
  output logic             i_or_d,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             reg_dst,
  output logic             reg_write,
  output logic             mem_to_reg,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic             illegal_op,
  output logic [CNT_W-1:0] instr_count
);

  state_t r_state;
  state_t w_next;
  logic   w_retire;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next        = r_state;
    w_retire      = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_source     = 2'b00;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    mem_to_reg    = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = ALUOP_ADD;
    illegal_op    = 1'b0;

    unique case (r_state)
      IDLE: w_next = FETCH;
      FETCH: begin
        // PC+4 is computed every FETCH cycle but only committed with the IR.
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        if (mem_ready) w_next = DECODE;
      end
      DECODE: begin
        alu_src_b = 2'b11;
        unique case (opcode)
          OP_RTYPE:       w_next = EXECUTE;
          OP_LW, OP_SW:   w_next = MEM_ADDR;
          OP_BEQ:         w_next = BRANCH;
          OP_J:           w_next = JUMP;
          OP_ADDI, OP_ANDI: w_next = IMM_EXEC;
          default: begin
            w_next     = FETCH;
            illegal_op = 1'b1;
          end
        endcase
      end
      MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        w_next    = (opcode == OP_LW) ? MEM_READ : MEM_WRITE;
      end
      MEM_READ: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        if (mem_ready) w_next = MEM_WB;
      end
      MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        w_next     = FETCH;
        w_retire   = 1'b1;
      end
      MEM_WRITE: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
        if (mem_ready) begin
          w_next   = FETCH;
          w_retire = 1'b1;
        end
      end
      EXECUTE: begin
        alu_src_a = 1'b1;
        alu_op    = ALUOP_FUNCT;
        w_next    = R_WB;
      end
      R_WB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        w_next    = FETCH;
        w_retire  = 1'b1;
      end
      BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = ALUOP_SUB;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
        w_next        = FETCH;
        w_retire      = 1'b1;
      end
      JUMP: begin
        pc_write  = 1'b1;
        pc_source = 2'b10;
        w_next    = FETCH;
        w_retire  = 1'b1;
      end
      IMM_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_op    = (opcode == OP_ANDI) ? ALUOP_AND : ALUOP_ADD;
        w_next    = IMM_WB;
      end
      IMM_WB: begin
        reg_write = 1'b1;
        w_next    = FETCH;
        w_retire  = 1'b1;
      end
      default: w_next = IDLE;
    endcase
  end

  instr_counter #(.CNT_W(CNT_W)) u_instr_counter (
    .i_clk   (clk),
    .i_rst   (reset),
    .i_en    (w_retire),
    .o_count (instr_count)
  );

endmodule
